// File: rtl/sgm_axil_pkg.sv
// Shared definitions for the AXI4-Lite register block: register offsets,
// response codes, FSM state types and the byte-strobe merge helper.
package sgm_axil_pkg;

    localparam logic [3:0] REG_0 = 4'h0;
    localparam logic [3:0] REG_1 = 4'h4;
    localparam logic [3:0] REG_2 = 4'h8;
    localparam logic [3:0] REG_3 = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // Bytes whose strobe is clear keep their previous contents.
    function automatic logic [31:0] strbMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
        logic [31:0] merged;
        merged = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = newVal[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sgm_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit registers, with independent write and
// read state machines and a per-register update pulse.
module sgm_axil_regs
    import sgm_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [3:0]                      reg_wr_o
);

    wstate_t     r_wState, w_wNext;
    rstate_t     r_rState, w_rNext;
    logic        r_live;
    logic [1:0]  r_awIdx;
    logic [31:0] r_wData;
    logic [3:0]  r_wStrb;
    logic [3:0][31:0] r_regs;
    logic [3:0]  r_regWr;
    logic [31:0] r_rdata;

    logic        w_awReady, w_wReady, w_arReady;
    logic        w_awHs, w_wHs, w_arHs;
    logic        w_commit;
    logic [1:0]  w_cmtIdx;
    logic [31:0] w_cmtData;
    logic [3:0]  w_cmtStrb;
    logic        w_unused;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies stay low until the first edge after reset releases.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_live   <= 1'b0;
            r_wState <= W_IDLE;
            r_rState <= R_IDLE;
        end else begin
            r_live   <= 1'b1;
            r_wState <= w_wNext;
            r_rState <= w_rNext;
        end
    end

    always_comb begin
        w_wNext   = r_wState;
        w_awReady = 1'b0;
        w_wReady  = 1'b0;
        w_commit  = 1'b0;
        w_cmtIdx  = S_AXI_AWADDR[3:2];
        w_cmtData = S_AXI_WDATA;
        w_cmtStrb = S_AXI_WSTRB;
        unique case (r_wState)
            W_IDLE: begin
                w_awReady = r_live;
                w_wReady  = r_live;
                if (S_AXI_AWVALID && w_awReady && S_AXI_WVALID && w_wReady) begin
                    w_commit = 1'b1;
                    w_wNext  = W_RESP;
                end else if (S_AXI_AWVALID && w_awReady) begin
                    w_wNext = W_HAVE_AW;
                end else if (S_AXI_WVALID && w_wReady) begin
                    w_wNext = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_wReady = 1'b1;
                w_cmtIdx = r_awIdx;
                if (S_AXI_WVALID) begin
                    w_commit = 1'b1;
                    w_wNext  = W_RESP;
                end
            end
            W_HAVE_W: begin
                w_awReady = 1'b1;
                w_cmtData = r_wData;
                w_cmtStrb = r_wStrb;
                if (S_AXI_AWVALID) begin
                    w_commit = 1'b1;
                    w_wNext  = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wNext = W_IDLE;
                end
            end
            default: w_wNext = W_IDLE;
        endcase
    end

    assign w_awHs = S_AXI_AWVALID && w_awReady;
    assign w_wHs  = S_AXI_WVALID && w_wReady;

    // Whichever half of the write arrives first is parked here.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awIdx <= 2'd0;
            r_wData <= 32'd0;
            r_wStrb <= 4'd0;
        end else begin
            if (w_awHs) begin
                r_awIdx <= S_AXI_AWADDR[3:2];
            end
            if (w_wHs) begin
                r_wData <= S_AXI_WDATA;
                r_wStrb <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_regs  <= '0;
            r_regWr <= 4'd0;
        end else begin
            r_regWr <= 4'd0;
            if (w_commit) begin
                r_regs[w_cmtIdx] <= strbMerge(r_regs[w_cmtIdx], w_cmtData, w_cmtStrb);
                r_regWr          <= 4'b0001 << w_cmtIdx;
            end
        end
    end

    always_comb begin
        w_rNext   = r_rState;
        w_arReady = 1'b0;
        unique case (r_rState)
            R_IDLE: begin
                w_arReady = r_live;
                if (S_AXI_ARVALID && w_arReady) begin
                    w_rNext = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rNext = R_IDLE;
                end
            end
            default: w_rNext = R_IDLE;
        endcase
    end

    assign w_arHs = S_AXI_ARVALID && w_arReady;

    // Sampled before any same-edge write lands, so a colliding read sees the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata <= 32'd0;
        end else if (w_arHs) begin
            r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
        end
    end

    assign S_AXI_AWREADY = w_awReady;
    assign S_AXI_WREADY  = w_wReady;
    assign S_AXI_BVALID  = (r_wState == W_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = w_arReady;
    assign S_AXI_RVALID  = (r_rState == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign regs_o        = r_regs;
    assign reg_wr_o      = r_regWr;

endmodule

// File: tb/tb_sgm_axil_regs.sv
// Self-checking bench for sgm_axil_regs: directed scenarios plus randomized
// traffic compared against a byte-level register model.
module tb_sgm_axil_regs;
    import sgm_axil_pkg::*;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] regs_o;
    logic [3:0]   reg_wr_o;

    int cmpCount = 0;
    int errCount = 0;
    logic [31:0] model [4];

    sgm_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .regs_o(regs_o), .reg_wr_o(reg_wr_o)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] modelRegs();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Reference write: each strobed byte replaces the stored byte.
    task automatic modelWrite(input int k, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[k][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Full write transaction, with AW/W presented after independent delays
    // and BREADY withheld for bDelay cycles once BVALID is seen.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int awDelay,
                                 input int wDelay, input int bDelay);
        int  cyc = 0;
        bit  awDone = 0;
        bit  wDone = 0;
        bit  awHs, wHs;
        int  k = int'(addr[3:2]);
        while (!(awDone && wDone) && cyc < 64) begin
            S_AXI_AWADDR  = addr;
            S_AXI_AWPROT  = 3'($urandom);
            S_AXI_WDATA   = data;
            S_AXI_WSTRB   = strb;
            S_AXI_AWVALID = !awDone && (cyc >= awDelay);
            S_AXI_WVALID  = !wDone && (cyc >= wDelay);
            if (awDone) checkOutput("awReadyAfterAw", 128'(S_AXI_AWREADY), 128'd0);
            if (wDone)  checkOutput("wReadyAfterW", 128'(S_AXI_WREADY), 128'd0);
            awHs = S_AXI_AWVALID && S_AXI_AWREADY;
            wHs  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            cyc++;
            awDone |= awHs;
            wDone  |= wHs;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(awDone && wDone)) begin
            checkOutput("writeHandshakeTimeout", 128'd0, 128'd1);
            return;
        end
        modelWrite(k, data, strb);
        checkOutput("bvalidRise", 128'(S_AXI_BVALID), 128'd1);
        checkOutput("bresp", 128'(S_AXI_BRESP), 128'(RESP_OKAY));
        checkOutput("regWrPulse", 128'(reg_wr_o), 128'(4'b0001 << k));
        checkOutput("regsAfterWrite", regs_o, modelRegs());
        for (int i = 0; i < bDelay; i++) begin
            @(negedge ACLK);
            checkOutput("bvalidHeld", 128'(S_AXI_BVALID), 128'd1);
            checkOutput("awReadyInResp", 128'(S_AXI_AWREADY), 128'd0);
            checkOutput("wReadyInResp", 128'(S_AXI_WREADY), 128'd0);
            checkOutput("regWrSingle", 128'(reg_wr_o), 128'd0);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        checkOutput("bvalidFall", 128'(S_AXI_BVALID), 128'd0);
        checkOutput("regWrCleared", 128'(reg_wr_o), 128'd0);
        checkOutput("awReadyBack", 128'(S_AXI_AWREADY), 128'd1);
    endtask

    // Read transaction; RDATA must stay put while RREADY is withheld.
    task automatic checkRead(input logic [3:0] addr, input logic [31:0] exp,
                             input int arDelay, input int rDelay);
        int cyc = 0;
        bit hs = 0;
        while (!hs && cyc < 64) begin
            S_AXI_ARADDR  = addr;
            S_AXI_ARPROT  = 3'($urandom);
            S_AXI_ARVALID = (cyc >= arDelay);
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!hs) begin
            checkOutput("readHandshakeTimeout", 128'd0, 128'd1);
            return;
        end
        checkOutput("rvalidRise", 128'(S_AXI_RVALID), 128'd1);
        checkOutput("rdata", 128'(S_AXI_RDATA), 128'(exp));
        checkOutput("rresp", 128'(S_AXI_RRESP), 128'(RESP_OKAY));
        for (int i = 0; i < rDelay; i++) begin
            @(negedge ACLK);
            checkOutput("rvalidHeld", 128'(S_AXI_RVALID), 128'd1);
            checkOutput("rdataHeld", 128'(S_AXI_RDATA), 128'(exp));
            checkOutput("arReadyInData", 128'(S_AXI_ARREADY), 128'd0);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        checkOutput("rvalidFall", 128'(S_AXI_RVALID), 128'd0);
        checkOutput("arReadyBack", 128'(S_AXI_ARREADY), 128'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Regs"}, regs_o, 128'd0);
        checkOutput({tag, "RegWr"}, 128'(reg_wr_o), 128'd0);
        checkOutput({tag, "Bvalid"}, 128'(S_AXI_BVALID), 128'd0);
        checkOutput({tag, "Rvalid"}, 128'(S_AXI_RVALID), 128'd0);
        checkOutput({tag, "Rdata"}, 128'(S_AXI_RDATA), 128'd0);
        checkOutput({tag, "Readies"},
                    128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'd0);
    endtask

    initial begin
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          k;

        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;

        repeat (3) @(negedge ACLK);
        checkResetState("reset");
        ARESET = 1'b0;
        checkOutput("readyBeforeEdge", 128'(S_AXI_AWREADY), 128'd0);
        @(negedge ACLK);
        checkOutput("readiesAfterReset",
                    128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'b111);

        // Four plain writes and readback.
        applyStimulus(REG_0, 32'h1, 4'hF, 0, 0, 0);
        applyStimulus(REG_1, 32'h2, 4'hF, 0, 1, 0);
        applyStimulus(REG_2, 32'h3, 4'hF, 1, 0, 0);
        applyStimulus(REG_3, 32'h4, 4'hF, 0, 0, 0);
        checkRead(REG_0, 32'h1, 0, 0);
        checkRead(REG_1, 32'h2, 0, 1);
        checkRead(REG_2, 32'h3, 0, 0);
        checkRead(REG_3, 32'h4, 2, 0);
        checkOutput("regsAfterFour", regs_o, 128'h00000004_00000003_00000002_00000001);

        // W leads AW by three cycles.
        applyStimulus(REG_2, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        checkOutput("reg2Deadbeef", 128'(regs_o[95:64]), 128'hDEADBEEF);

        // Partial strobe merge.
        applyStimulus(REG_1, 32'h00000001, 4'hF, 0, 0, 0);
        applyStimulus(REG_1, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
        checkOutput("reg1Strobe", 128'(regs_o[63:32]), 128'h0000CC01);

        // Response withheld for five cycles.
        applyStimulus(REG_3, 32'h12345678, 4'hF, 0, 0, 5);

        // Read colliding with a write to the same register.
        applyStimulus(REG_1, 32'h2, 4'hF, 0, 0, 0);
        fork
            applyStimulus(REG_1, 32'h7, 4'hF, 0, 0, 0);
            checkRead(REG_1, 32'h2, 0, 0);
        join
        checkRead(REG_1, 32'h7, 0, 0);

        // Reset between AW and W.
        S_AXI_AWADDR  = REG_3;
        S_AXI_AWVALID = 1'b1;
        checkOutput("awReadyBeforeAbort", 128'(S_AXI_AWREADY), 128'd1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        #1;
        checkResetState("midReset");
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            checkOutput("noBvalidAfterAbort", 128'(S_AXI_BVALID), 128'd0);
            checkOutput("noRvalidAfterAbort", 128'(S_AXI_RVALID), 128'd0);
        end
        checkOutput("regsAfterAbort", regs_o, 128'd0);
        applyStimulus(REG_3, 32'h5, 4'hF, 0, 0, 0);
        checkRead(REG_3, 32'h5, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            k    = int'($urandom_range(0, 3));
            addr = {2'(k), 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom);
                applyStimulus(addr, data, strb, int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                checkRead(addr, model[k], int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)));
            end
        end
        checkOutput("regsFinal", regs_o, modelRegs());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/sgm_axil_regs.md
SGM_AXIL_REGS -- requirements
Module: sgm_axil_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, 4, byte address width, giving four 32-bit registers.
REQ-003 ACLK  in  1  single clock; all logic is rising-edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 S_AXI_AWADDR in 4, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write-address channel.
REQ-006 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write-data channel.
REQ-007 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write-response channel.
REQ-008 S_AXI_ARADDR in 4, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read-address channel.
REQ-009 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read-data channel.
REQ-010 regs_o  out  128  register contents; reg k occupies bits [32k+31:32k].
REQ-011 reg_wr_o  out  4  one-cycle pulse, bit k set in the cycle register k is updated.

Function
REQ-012 Register k is decoded from ADDR[3:2]; ADDR[1:0] and PROT are ignored.
REQ-013 Write FSM states are W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
- W_IDLE: AWREADY=1 and WREADY=1.
- W_HAVE_AW: AWREADY=0 and WREADY=1.
- W_HAVE_W: AWREADY=1 and WREADY=0.
- W_RESP: AWREADY=0 and WREADY=0.
REQ-014 AW and W handshakes are accepted in either order or in the same cycle; the address and data/strobe of the first handshake are latched.
REQ-015 The register is written on the clock edge that completes the second handshake (or both in W_IDLE). The FSM then enters W_RESP, and BVALID=1 from the next cycle.
REQ-016 WSTRB bit b gates byte b, so unstrobed bytes keep their old value.
REQ-017 reg_wr_o[k] pulses in the cycle after the write edge, aligned with BVALID rising.
REQ-018 BVALID is held with BRESP=OKAY (2'b00) until BREADY; the FSM returns to W_IDLE on the BVALID&BREADY edge; no new AW or W is accepted in W_RESP.
REQ-019 Read FSM states are R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
- On an AR handshake, RDATA is registered from the addressed register, and RVALID=1 next cycle.
- RDATA and RVALID are held stable until RREADY, then the FSM returns to R_IDLE.
REQ-020 RRESP is always OKAY; no address is out of range.
REQ-021 Read and write FSMs are independent. If an AR handshake and a register write to the same register occur in the same cycle, the read returns the pre-write value.
REQ-022 Minimum latency is 1 cycle from the final handshake to BVALID, and 1 cycle from the AR handshake to RVALID; throughput is one write per 2 cycles and one read per 2 cycles.

Reset
REQ-023 While ARESET=1 the following are forced low or zero: all registers, regs_o, reg_wr_o, BVALID, RVALID, RDATA, AWREADY, WREADY and ARREADY. Both FSMs go to their IDLE states.
REQ-024 After ARESET deasserts, the READY outputs rise on the first clock edge.
REQ-025 Reset mid-transaction abandons it with no register update, and no B or R response is issued after reset.

Structure
REQ-026 Package sgm_axil_pkg holds:
- register offset constants (REG_0..REG_3 = 0x0, 0x4, 0x8, 0xC);
- the RESP_OKAY constant;
- the write-FSM and read-FSM state enum typedefs.
REQ-027 The block is a single module with no sub-module; byte-strobe merge is a function in sgm_axil_pkg.

Verification
REQ-028 Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back 0x0..0xC -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY, and regs_o=0x00000004_00000003_00000002_00000001.
REQ-029 W presented 3 cycles before AW (addr 0x8, data 0xDEADBEEF) -> WREADY drops after the W handshake, the write commits on AW, and reg2=0xDEADBEEF with reg_wr_o=4'b0100 for one cycle.
REQ-030 reg1=0x00000001, then write 0xAABBCCDD with WSTRB=4'b0010 -> reg1=0x0000CC01.
REQ-031 BREADY held low 5 cycles after BVALID -> BVALID stays 1, AWREADY/WREADY stay 0, and a second AW is not accepted until the B handshake.
REQ-032 Same-cycle AR and write-commit to 0x4 (old 0x2, new 0x7) -> RDATA=0x2, and a following read gives 0x7.
REQ-033 ARESET pulsed after the AW handshake but before W -> no BVALID, all regs 0, and the subsequent write/read of 0x5 at 0xC works normally.
